// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART blocks.
// The state enum is shared so the transmitter can reuse the same naming.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every CLK_FRQ/(BAUD*OVERSAMPLE) clocks.
// clr restarts the period so the following ticks line up with a detected start edge.
module uart_baud_tick #(
  parameter int CLK_FRQ    = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FRQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_tick: divider below 2, raise CLK_FRQ or lower BAUD*OVERSAMPLE");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q - CW'(1);
    if (clr) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity,
// 1 or 2 stop bits and a valid/ready output register with overrun detection.
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on rx_s
// START  | inside the start bit, vote decides real start or glitch
// DATA   | shifting payload bits, LSB first
// PARITY | checking the parity bit against the payload
// STOP   | sampling stop bits, delivers the word on the last good one
// BREAK  | stop bit was 0, wait for the line to return high
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FRQ    = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiid,
  input  logic                 axior,
  output logic                 axiov,
  output logic [DATA_BITS-1:0] axiod,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_rx_ovs: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_rx_ovs: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_ovs: DATA_BITS must be 5..9");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_chk_ovs
    $error("uart_rx_ovs: OVERSAMPLE must be even and >= 8");
  end

  logic                 sync1_q, rx_s_q, rx_p_q;
  rx_state_t            state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [1:0]           smp_q, smp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_err_q, par_err_d;
  logic                 axiov_q, axiov_d;
  logic [DATA_BITS-1:0] axiod_q, axiod_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, clr, vote, at_vote, exp_par;

  assign clr     = (state_q == IDLE) && rx_p_q && !rx_s_q;
  assign vote    = maj3(smp_q[1], smp_q[0], rx_s_q);
  assign at_vote = tick && (s_q == SW'(H + 1));
  assign exp_par = (PARITY == PAR_ODD) ? ~(^data_q) : (^data_q);

  uart_baud_tick #(
    .CLK_FRQ   (CLK_FRQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    smp_d        = smp_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    data_d       = data_q;
    par_err_d    = par_err_q;
    axiov_d      = axiov_q && !axior;
    axiod_d      = axiod_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    if (tick && state_q != IDLE) begin
      s_d = (s_q == SW'(OVERSAMPLE - 1)) ? '0 : s_q + SW'(1);
      if (s_q == SW'(H - 1) || s_q == SW'(H)) smp_d = {smp_q[0], rx_s_q};
    end

    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = START;
          s_d       = '0;
          bit_d     = '0;
          stop_d    = 1'b0;
          par_err_d = 1'b0;
        end
      end
      START: if (at_vote) state_d = vote ? IDLE : DATA;
      DATA: begin
        if (at_vote) begin
          data_d = {vote, data_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          else                             bit_d   = bit_q + BW'(1);
        end
      end
      uart_pkg::PARITY: begin
        if (at_vote) begin
          par_err_d = (vote != exp_par);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (at_vote) begin
          if (!vote) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
            // a word still waiting downstream wins over the new one
            if (par_err_q)             parity_err_d = 1'b1;
            else if (axiov_q && !axior) overrun_d   = 1'b1;
            else begin
              axiod_d = data_q;
              axiov_d = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      BREAK:   if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_p_q       <= 1'b1;
      state_q      <= IDLE;
      s_q          <= '0;
      smp_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      data_q       <= '0;
      par_err_q    <= 1'b0;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= axiid;
      rx_s_q       <= sync1_q;
      rx_p_q       <= rx_s_q;
      state_q      <= state_d;
      s_q          <= s_d;
      smp_q        <= smp_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      data_q       <= data_d;
      par_err_q    <= par_err_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: three instances (8N1, 8E1, 7N2) share one serial line.
`timescale 1ns/1ps
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam real BIT_NS = 8680.0;

  logic clk = 1'b0;
  logic rst, rx_line, axior_a, axior_p, axior_b;
  logic axiov_a, pe_a_s, fe_a_s, ov_a_s;
  logic [7:0] axiod_a;
  logic axiov_p, pe_p_s, fe_p_s, ov_p_s;
  logic [7:0] axiod_p;
  logic axiov_b, pe_b_s, fe_b_s, ov_b_s;
  logic [6:0] axiod_b;

  int checks = 0, failures = 0;
  int pe_a = 0, fe_a = 0, ov_a = 0, pe_p = 0, fe_b = 0;
  logic [8:0] q_a[$], q_p[$], q_b[$];

  always #10 clk = ~clk;

  uart_rx_ovs #(.CLK_FRQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .axiid(rx_line), .axior(axior_a), .axiov(axiov_a), .axiod(axiod_a),
    .parity_err(pe_a_s), .frame_err(fe_a_s), .overrun(ov_a_s));

  uart_rx_ovs #(.CLK_FRQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .axiid(rx_line), .axior(axior_p), .axiov(axiov_p), .axiod(axiod_p),
    .parity_err(pe_p_s), .frame_err(fe_p_s), .overrun(ov_p_s));

  uart_rx_ovs #(.CLK_FRQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .axiid(rx_line), .axior(axior_b), .axiov(axiov_b), .axiod(axiod_b),
    .parity_err(pe_b_s), .frame_err(fe_b_s), .overrun(ov_b_s));

  always @(negedge clk) begin
    if (axiov_a && axior_a) q_a.push_back({1'b0, axiod_a});
    if (axiov_p && axior_p) q_p.push_back({1'b0, axiod_p});
    if (axiov_b && axior_b) q_b.push_back({2'b00, axiod_b});
    if (pe_a_s) pe_a++;
    if (fe_a_s) fe_a++;
    if (ov_a_s) ov_a++;
    if (pe_p_s) pe_p++;
    if (fe_b_s) fe_b++;
  end

  // spike_bit >= 0 pulls that data bit low for one tick period near its middle
  task automatic send_frame(input logic [8:0] data, input int nbits, input int par_mode,
                            input bit par_flip, input int nstop, input bit stop_val,
                            input real bit_ns, input int spike_bit);
    logic p;
    p = 1'b0;
    rx_line = 1'b0;
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      p = p ^ data[i];
      rx_line = data[i];
      if (i == spike_bit) begin
        #(bit_ns * 0.55);
        rx_line = 1'b0;
        #540;
        rx_line = data[i];
        #(bit_ns * 0.45 - 540.0);
      end else begin
        #(bit_ns);
      end
    end
    if (par_mode != 0) begin
      if (par_mode == 1) p = ~p;
      rx_line = p ^ par_flip;
      #(bit_ns);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_line = stop_val;
      #(bit_ns);
    end
  endtask

  task automatic idle(input real nbits);
    rx_line = 1'b1;
    #(BIT_NS * nbits);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_line = 1'b1; axior_a = 1'b1; axior_p = 1'b1; axior_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({axiov_a, pe_a_s, fe_a_s, ov_a_s, axiod_a} !== 12'h000) begin
      failures++; $display("FAIL reset_outs_a got=%0h exp=0", {axiov_a, pe_a_s, fe_a_s, ov_a_s, axiod_a});
    end
    checks++;
    if ({axiov_p, pe_p_s, fe_p_s, ov_p_s, axiod_p} !== 12'h000) begin
      failures++; $display("FAIL reset_outs_p got=%0h exp=0", {axiov_p, pe_p_s, fe_p_s, ov_p_s, axiod_p});
    end
    checks++;
    if (dut_a.state_q !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dut_a.state_q, IDLE);
    end
    @(negedge clk) rst = 1'b0;
    idle(2);
  endtask

  task automatic test_8n1;
    int base, fe0, pe0;
    base = q_a.size(); fe0 = fe_a; pe0 = pe_a;
    send_frame(9'h0A5, 8, 0, 0, 1, 1, BIT_NS, -1);
    idle(2);
    checks++;
    if (q_a.size() !== base + 1) begin
      failures++; $display("FAIL a5_count got=%0d exp=%0d", q_a.size() - base, 1);
    end else begin
      checks++;
      if (q_a[base] !== 9'h0A5) begin
        failures++; $display("FAIL a5_data got=%0h exp=a5", q_a[base]);
      end
    end
    checks++;
    if (fe_a - fe0 != 0 || pe_a - pe0 != 0) begin
      failures++; $display("FAIL a5_flags got=fe%0d/pe%0d exp=0/0", fe_a - fe0, pe_a - pe0);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = q_a.size();
    send_frame(9'h000, 8, 0, 0, 1, 1, BIT_NS, -1);
    send_frame(9'h0FF, 8, 0, 0, 1, 1, BIT_NS, -1);
    idle(2);
    checks++;
    if (q_a.size() !== base + 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", q_a.size() - base);
    end else begin
      checks++;
      if (q_a[base] !== 9'h000 || q_a[base+1] !== 9'h0FF) begin
        failures++; $display("FAIL b2b_data got=%0h,%0h exp=0,ff", q_a[base], q_a[base+1]);
      end
    end
  endtask

  task automatic test_parity;
    int base, pe0;
    base = q_p.size(); pe0 = pe_p;
    send_frame(9'h03C, 8, 2, 0, 1, 1, BIT_NS, -1);
    idle(2);
    checks++;
    if (q_p.size() !== base + 1 || q_p[q_p.size()-1] !== 9'h03C) begin
      failures++; $display("FAIL par_good got=%0d words exp=1 word 3c", q_p.size() - base);
    end
    send_frame(9'h03C, 8, 2, 1, 1, 1, BIT_NS, -1);
    idle(2);
    checks++;
    if (pe_p - pe0 !== 1) begin
      failures++; $display("FAIL par_err_pulse got=%0d exp=1", pe_p - pe0);
    end
    checks++;
    if (q_p.size() !== base + 1 || axiov_p !== 1'b0) begin
      failures++; $display("FAIL par_bad_discard got=%0d words exp=1", q_p.size() - base);
    end
  endtask

  task automatic test_frame_err;
    int base, fe0;
    base = q_a.size(); fe0 = fe_a;
    send_frame(9'h055, 8, 0, 0, 1, 0, BIT_NS, -1);
    #(BIT_NS * 5.0);
    checks++;
    if (dut_a.state_q !== BREAK) begin
      failures++; $display("FAIL break_hold got=%0d exp=%0d", dut_a.state_q, BREAK);
    end
    idle(2);
    checks++;
    if (fe_a - fe0 !== 1) begin
      failures++; $display("FAIL frame_err_count got=%0d exp=1", fe_a - fe0);
    end
    checks++;
    if (q_a.size() !== base || dut_a.state_q !== IDLE) begin
      failures++; $display("FAIL frame_err_discard got=%0d words st=%0d exp=0 words st=%0d", q_a.size() - base, dut_a.state_q, IDLE);
    end
  endtask

  task automatic test_glitch;
    int base;
    base = q_a.size();
    rx_line = 1'b0;
    #(BIT_NS * 0.25);
    idle(2);
    checks++;
    if (q_a.size() !== base || dut_a.state_q !== IDLE) begin
      failures++; $display("FAIL glitch got=%0d words st=%0d exp=0 words st=%0d", q_a.size() - base, dut_a.state_q, IDLE);
    end
    send_frame(9'h00F, 8, 0, 0, 1, 1, BIT_NS, 3);
    idle(2);
    checks++;
    if (q_a.size() !== base + 1 || q_a[q_a.size()-1] !== 9'h00F) begin
      failures++; $display("FAIL spike_vote got=%0d words last=%0h exp=1 word f", q_a.size() - base, q_a[q_a.size()-1]);
    end
  endtask

  task automatic test_overrun;
    int base, ov0;
    base = q_a.size(); ov0 = ov_a;
    axior_a = 1'b0;
    send_frame(9'h011, 8, 0, 0, 1, 1, BIT_NS, -1);
    send_frame(9'h022, 8, 0, 0, 1, 1, BIT_NS, -1);
    idle(2);
    checks++;
    if (axiov_a !== 1'b1 || axiod_a !== 8'h11) begin
      failures++; $display("FAIL overrun_hold got=v%0b d%0h exp=v1 d11", axiov_a, axiod_a);
    end
    checks++;
    if (ov_a - ov0 !== 1) begin
      failures++; $display("FAIL overrun_pulse got=%0d exp=1", ov_a - ov0);
    end
    @(posedge clk); #1 axior_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (q_a.size() !== base + 1 || q_a[q_a.size()-1] !== 9'h011 || axiov_a !== 1'b0) begin
      failures++; $display("FAIL overrun_xfer got=%0d words v%0b exp=1 word 11 v0", q_a.size() - base, axiov_a);
    end
  endtask

  task automatic test_reset_midframe;
    int base, baseb, fe0;
    axior_a = 1'b0;
    send_frame(9'h033, 8, 0, 0, 1, 1, BIT_NS, -1);
    idle(1);
    checks++;
    if (axiov_a !== 1'b1 || axiod_a !== 8'h33) begin
      failures++; $display("FAIL pre_rst_hold got=v%0b d%0h exp=v1 d33", axiov_a, axiod_a);
    end
    fe0 = fe_a;
    rx_line = 1'b0; #(BIT_NS);
    for (int i = 0; i < 4; i++) begin rx_line = i[0]; #(BIT_NS); end
    rx_line = 1'b1; #(BIT_NS * 0.5);
    rst = 1'b1;
    #1;
    checks++;
    if ({axiov_a, pe_a_s, fe_a_s, ov_a_s, axiod_a} !== 12'h000) begin
      failures++; $display("FAIL rst_mid_outs got=%0h exp=0", {axiov_a, pe_a_s, fe_a_s, ov_a_s, axiod_a});
    end
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 axior_a = 1'b1;
    idle(4);
    base = q_a.size();
    send_frame(9'h07E, 8, 0, 0, 1, 1, BIT_NS, -1);
    idle(2);
    checks++;
    if (q_a.size() !== base + 1 || q_a[q_a.size()-1] !== 9'h07E || fe_a !== fe0) begin
      failures++; $display("FAIL rst_recover got=%0d words fe%0d exp=1 word 7e fe0", q_a.size() - base, fe_a - fe0);
    end
    baseb = q_b.size(); fe0 = fe_b;
    send_frame(9'h05A, 7, 0, 0, 2, 1, BIT_NS * 1.02, -1);
    idle(2);
    send_frame(9'h025, 7, 0, 0, 2, 1, BIT_NS * 0.98, -1);
    idle(2);
    checks++;
    if (q_b.size() !== baseb + 2) begin
      failures++; $display("FAIL skew_count got=%0d exp=2", q_b.size() - baseb);
    end else begin
      checks++;
      if (q_b[baseb] !== 9'h05A || q_b[baseb+1] !== 9'h025) begin
        failures++; $display("FAIL skew_data got=%0h,%0h exp=5a,25", q_b[baseb], q_b[baseb+1]);
      end
    end
    checks++;
    if (fe_b !== fe0) begin
      failures++; $display("FAIL skew_frame_err got=%0d exp=0", fe_b - fe0);
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_back_to_back;
    test_parity;
    test_frame_err;
    test_glitch;
    test_overrun;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
